// File: rtl/series.sv
// Serial pattern detector with a KMP-style fallback table built from PATTERN at elaboration.
// Define SERIES_NONOVERLAP_EN to restart from an empty match after each hit.
module series #(
  parameter int unsigned           LEN     = 4,
  parameter logic [LEN-1:0]        PATTERN = 4'b1010
) (
  input  logic clk,
  input  logic x,
  input  logic rst,
  output logic z
);

  localparam int unsigned SW = (LEN > 1) ? $clog2(LEN) : 1;

  // Entry {k,b}: longest prefix of PATTERN that is a suffix of (first k pattern bits, then b),
  // capped below LEN so a full match lands on the pattern's longest proper border.
  function automatic logic [2*LEN*SW-1:0] build_tbl();
    logic [2*LEN*SW-1:0] t;
    logic [LEN-1:0]      s;
    int unsigned         best;
    logic                ok;
    t = '0;
    for (int unsigned k = 0; k < LEN; k++) begin
      for (int unsigned b = 0; b < 2; b++) begin
        s = '0;
        for (int unsigned i = 0; i < k; i++) s[i] = PATTERN[LEN-1-i];
        s[k] = b[0];
        best = 0;
        for (int unsigned j = 1; j <= k + 1 && j < LEN; j++) begin
          ok = 1'b1;
          for (int unsigned m = 0; m < j; m++)
            if (s[k+1-j+m] != PATTERN[LEN-1-m]) ok = 1'b0;
          if (ok) best = j;
        end
        t[(k*2+b)*SW +: SW] = SW'(best);
      end
    end
    return t;
  endfunction

  function automatic logic [LEN-1:0] build_exp();
    logic [LEN-1:0] e;
    for (int unsigned k = 0; k < LEN; k++) e[k] = PATTERN[LEN-1-k];
    return e;
  endfunction

  localparam logic [2*LEN*SW-1:0] NXT_TBL = build_tbl();
  localparam logic [LEN-1:0]      EXP     = build_exp();

  logic [SW-1:0] nxt_tbl [2*LEN];
  for (genvar g = 0; g < 2*LEN; g++) begin : g_tbl
    assign nxt_tbl[g] = NXT_TBL[g*SW +: SW];
  end

  logic [SW-1:0] state, state_n;
  logic          z_n;
  logic          hit;

  always_comb begin
    state_n = nxt_tbl[{state, x}];
    hit     = (state == SW'(LEN-1)) && (x == EXP[state]);
    z_n     = hit;
`ifdef SERIES_NONOVERLAP_EN
    if (hit) state_n = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= '0;
      z     <= 1'b0;
    end else begin
      state <= state_n;
      z     <= z_n;
    end
  end

endmodule

// File: tb/tb_series.sv
// Directed bench for series: default 1010, LEN=5 11011 and LEN=2 11 instances share one stream.
module tb_series;

  logic clk;
  logic x;
  logic rst;
  logic z4, z5, z2;
  int   total;
  int   bad;

  series #(.LEN(4), .PATTERN(4'b1010)) dut4 (.clk(clk), .x(x), .rst(rst), .z(z4));
  series #(.LEN(5), .PATTERN(5'b11011)) dut5 (.clk(clk), .x(x), .rst(rst), .z(z5));
  series #(.LEN(2), .PATTERN(2'b11)) dut2 (.clk(clk), .x(x), .rst(rst), .z(z2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic r, input logic b);
    rst = r;
    x   = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input int unsigned which);
    case (which)
      5:       return z5;
      2:       return z2;
      default: return z4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: z=%0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic reset_chk(input string tag);
    tick(1'b0, 1'b1);
    chk({tag, "_rst4"}, z4, 1'b0);
    chk({tag, "_rst5"}, z5, 1'b0);
    chk({tag, "_rst2"}, z2, 1'b0);
  endtask

  // bits[n-1] is the first bit sent; expz[n-1] is z after that bit's edge
  task automatic run_seq(input string tag, input int unsigned which,
                         input logic [15:0] bits, input logic [15:0] expz, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick(1'b1, bits[n-1-i]);
      chk($sformatf("%s_b%0d", tag, i + 1), pick(which), expz[n-1-i]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    x     = 1'b0;

    tick(1'b0, 1'b1);
    chk("rst_a4", z4, 1'b0);
    chk("rst_a5", z5, 1'b0);
    chk("rst_a2", z2, 1'b0);
    tick(1'b0, 1'b0);
    chk("rst_b4", z4, 1'b0);
    chk("rst_b5", z5, 1'b0);
    chk("rst_b2", z2, 1'b0);
    run_seq("basic", 4, 16'b1010, 16'b0001, 4);

    reset_chk("ovl");
`ifdef SERIES_NONOVERLAP_EN
    run_seq("ovl", 4, 16'b110101011, 16'b000010000, 9);
`else
    run_seq("ovl", 4, 16'b110101011, 16'b000010100, 9);
`endif

    reset_chk("mid");
    run_seq("mid_pre", 4, 16'b101, 16'b000, 3);
    tick(1'b0, 1'b1);
    chk("mid_rst", z4, 1'b0);
    tick(1'b1, 1'b0);
    chk("mid_x0", z4, 1'b0);
    run_seq("mid_post", 4, 16'b1010, 16'b0001, 4);

    reset_chk("fb");
    run_seq("fb", 4, 16'b1011010, 16'b0000001, 7);

    reset_chk("len5");
`ifdef SERIES_NONOVERLAP_EN
    run_seq("len5", 5, 16'b11011011, 16'b00001000, 8);
`else
    run_seq("len5", 5, 16'b11011011, 16'b00001001, 8);
`endif

    reset_chk("len2");
`ifdef SERIES_NONOVERLAP_EN
    run_seq("len2", 2, 16'b111, 16'b010, 3);
`else
    run_seq("len2", 2, 16'b111, 16'b011, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
